// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event pulses into fixed-length level pulses. A 1-cycle trigger-to-output latency.
// Triggers arriving while busy are queued or replayed after a gap, or restart the running pulse.
module pulse_stretcher #(
  parameter int PULSE_LEN   = 25000000,
  parameter int GAP_LEN     = 5000000,
  parameter int MAX_PENDING = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               trigger,
  output logic                               pulse_out,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending
);

  localparam int LONGEST = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW      = $clog2(LONGEST + 1);
  localparam int PW      = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            pend_full;

  assign pend_full = (pend_q == PEND_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ACTIVE;
          cnt_d   = PULSE_LOAD;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ACTIVE: begin
        if ((RETRIGGER != 0) && trigger) begin
          cnt_d = PULSE_LOAD;
        end else begin
          if (trigger) begin
            if (pend_full) ovf_d  = 1'b1;
            else           pend_d = pend_q + PW'(1);
          end
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            pulse_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          // A trigger here is consumed directly; it cancels against the dequeue.
          if (trigger || (pend_q != '0)) begin
            state_d = ACTIVE;
            cnt_d   = PULSE_LOAD;
            pulse_d = 1'b1;
            if (!trigger) pend_d = pend_q - PW'(1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (trigger) begin
            if (pend_full) ovf_d  = 1'b1;
            else           pend_d = pend_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = '0;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: three configurations share one trigger; a timestamp model predicts every output cycle.
module tb_pulse_stretcher;

  localparam int PL [3] = '{4, 4, 4};
  localparam int GL [3] = '{2, 2, 3};
  localparam int MP [3] = '{3, 2, 2};
  localparam int RT [3] = '{0, 0, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trigger = 1'b0;

  wire [2:0]      pulse_a, busy_a, done_a, ovf_a;
  wire [2:0][1:0] pend_a;

  always #5 clk = ~clk;

  pulse_stretcher #(.PULSE_LEN(PL[0]), .GAP_LEN(GL[0]), .MAX_PENDING(MP[0]), .RETRIGGER(RT[0])) u0 (
    .clk(clk), .reset(reset), .trigger(trigger), .pulse_out(pulse_a[0]), .busy(busy_a[0]),
    .done(done_a[0]), .overflow(ovf_a[0]), .pending(pend_a[0]));
  pulse_stretcher #(.PULSE_LEN(PL[1]), .GAP_LEN(GL[1]), .MAX_PENDING(MP[1]), .RETRIGGER(RT[1])) u1 (
    .clk(clk), .reset(reset), .trigger(trigger), .pulse_out(pulse_a[1]), .busy(busy_a[1]),
    .done(done_a[1]), .overflow(ovf_a[1]), .pending(pend_a[1]));
  pulse_stretcher #(.PULSE_LEN(PL[2]), .GAP_LEN(GL[2]), .MAX_PENDING(MP[2]), .RETRIGGER(RT[2])) u2 (
    .clk(clk), .reset(reset), .trigger(trigger), .pulse_out(pulse_a[2]), .busy(busy_a[2]),
    .done(done_a[2]), .overflow(ovf_a[2]), .pending(pend_a[2]));

  typedef struct packed {
    logic [2:0]      pulse;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0]      ovf;
    logic [2:0][1:0] pend;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model keeps absolute cycle stamps: pulse start, last high cycle, last gap cycle.
  int t = 0;
  int ps [3], pe [3], ge [3], pd [3];
  int hi_cnt [3], busy_cnt [3], done_cnt [3], ovf_cnt [3], pmax [3];

  task automatic check(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] at t=%0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ps[i] = -100; pe[i] = -100; ge[i] = -100; pd[i] = 0;
      hi_cnt[i] = 0; busy_cnt[i] = 0; done_cnt[i] = 0; ovf_cnt[i] = 0; pmax[i] = 0;
    end
  endtask

  task automatic start_pulse(input int i);
    ps[i] = t;
    pe[i] = t + PL[i] - 1;
    ge[i] = pe[i] + GL[i];
  endtask

  task automatic model_edge(input bit tr);
    exp_t e;
    t++;
    for (int i = 0; i < 3; i++) begin
      bit ov, in_act, in_gap;
      ov = 1'b0;
      in_act = (ps[i] <= t - 1) && (t - 1 <= pe[i]);
      in_gap = (pe[i] < t - 1) && (t - 1 <= ge[i]);
      if (in_act) begin
        if (RT[i] != 0 && tr) begin
          pe[i] = t + PL[i] - 1;
          ge[i] = pe[i] + GL[i];
        end else if (tr) begin
          if (pd[i] == MP[i]) ov = 1'b1; else pd[i]++;
        end
      end else if (in_gap) begin
        if (t - 1 == ge[i]) begin
          if (tr || pd[i] > 0) begin
            if (!tr) pd[i]--;
            start_pulse(i);
          end
        end else if (tr) begin
          if (pd[i] == MP[i]) ov = 1'b1; else pd[i]++;
        end
      end else if (tr) begin
        start_pulse(i);
      end
      e.pulse[i] = (ps[i] <= t) && (t <= pe[i]);
      e.busy[i]  = (ps[i] <= t) && (t <= ge[i]);
      e.done[i]  = (t == pe[i] + 1);
      e.ovf[i]   = ov;
      e.pend[i]  = 2'(pd[i]);
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_empty at t=%0t: got no expectation, required one per cycle", $time);
      end else begin
        mon_e = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("pulse_out", i, int'(pulse_a[i]), int'(mon_e.pulse[i]));
          check("busy", i, int'(busy_a[i]), int'(mon_e.busy[i]));
          check("done", i, int'(done_a[i]), int'(mon_e.done[i]));
          check("overflow", i, int'(ovf_a[i]), int'(mon_e.ovf[i]));
          check("pending", i, int'(pend_a[i]), int'(mon_e.pend[i]));
          hi_cnt[i]   += int'(pulse_a[i]);
          busy_cnt[i] += int'(busy_a[i]);
          done_cnt[i] += int'(done_a[i]);
          ovf_cnt[i]  += int'(ovf_a[i]);
          if (int'(pend_a[i]) > pmax[i]) pmax[i] = int'(pend_a[i]);
        end
      end
    end
  end

  task automatic step(input bit tr);
    trigger = tr;
    @(posedge clk);
    model_edge(tr);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    trigger = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_pulse", i, int'(pulse_a[i]), 0);
      check("rst_busy", i, int'(busy_a[i]), 0);
      check("rst_done", i, int'(done_a[i]), 0);
      check("rst_ovf", i, int'(ovf_a[i]), 0);
      check("rst_pend", i, int'(pend_a[i]), 0);
    end
    sbq.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    int burst;
    model_reset();

    // Single trigger
    do_reset();
    step(1'b1); idle_steps(10);
    check("s1_high_cycles", 0, hi_cnt[0], 4);
    check("s1_busy_cycles", 0, busy_cnt[0], 6);
    check("s1_done_count", 0, done_cnt[0], 1);

    // Three queued triggers during the first pulse
    do_reset();
    step(1'b1); step(1'b1); step(1'b1); step(1'b1); idle_steps(30);
    check("s2_high_cycles", 0, hi_cnt[0], 16);
    check("s2_done_count", 0, done_cnt[0], 4);
    check("s2_peak_pending", 0, pmax[0], 3);

    // Held trigger saturating a depth-2 queue
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1);
    idle_steps(30);
    check("s3_overflow_count", 1, ovf_cnt[1], 3);
    check("s3_done_count", 1, done_cnt[1], 3);
    check("s3_peak_pending", 1, pmax[1], 2);

    // Retrigger extends the running pulse
    do_reset();
    step(1'b1); step(1'b0); step(1'b0); step(1'b1); idle_steps(20);
    check("s4_high_cycles", 2, hi_cnt[2], 7);
    check("s4_done_count", 2, done_cnt[2], 1);

    // Trigger on the final gap cycle with nothing queued
    do_reset();
    step(1'b1); idle_steps(5); step(1'b1); idle_steps(15);
    check("s5_high_cycles", 0, hi_cnt[0], 8);
    check("s5_busy_cycles", 0, busy_cnt[0], 12);
    check("s5_overflow_count", 0, ovf_cnt[0], 0);

    // Asynchronous reset mid-pulse with two queued
    do_reset();
    step(1'b1); step(1'b1); step(1'b1);
    mon_en = 1'b0;
    #1;
    check("s6_pend_before", 0, int'(pend_a[0]), 2);
    reset = 1'b1;
    #1;
    check("s6_async_pulse", 0, int'(pulse_a[0]), 0);
    check("s6_async_busy", 0, int'(busy_a[0]), 0);
    check("s6_async_pend", 0, int'(pend_a[0]), 0);
    do_reset();
    step(1'b1);
    #2;
    check("s6_latency", 0, int'(pulse_a[0]), 1);
    idle_steps(10);

    // Randomized traffic with occasional held bursts
    do_reset();
    burst = 0;
    for (int k = 0; k < 1500; k++) begin
      int r;
      if (burst > 0) begin
        burst--;
        step(1'b1);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 3) burst = $urandom_range(1, 6);
        step(r < 18);
      end
    end
    idle_steps(40);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("sb_drain", 0, sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
